jtlabrun_gfxcfg: RTL and testbench



---
 rtl/jtlabrun_gfxcfg_pkg.sv | 24 ++
 rtl/jtlabrun_irqgen.sv | 110 +++++++++++
 rtl/jtlabrun_gfxcfg.sv | 123 ++++++++++++
 tb/tb_jtlabrun_gfxcfg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtlabrun_gfxcfg_pkg.sv
// Shared constants for the Labyrinth Runner video config block:
// register indices within the 8-byte config bank, bit positions
// inside the interrupt/flip register, and the IRQ state encoding.
package jtlabrun_gfxcfg_pkg;

  localparam logic [2:0] REG_SCRXL = 3'd0;
  localparam logic [2:0] REG_SCRXH = 3'd1;
  localparam logic [2:0] REG_SCRY  = 3'd2;
  localparam logic [2:0] REG_CTL3  = 3'd3;
  localparam logic [2:0] REG_CTL4  = 3'd4;
  localparam logic [2:0] REG_CTL5  = 3'd5;
  localparam logic [2:0] REG_CTL6  = 3'd6;
  localparam logic [2:0] REG_INT   = 3'd7;

  localparam int INT_NMI  = 0;
  localparam int INT_IRQ  = 1;
  localparam int INT_FLIP = 3;

  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_ASSERT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/jtlabrun_irqgen.sv
// Blanking edge detectors plus the IRQ (per frame) and NMI (every
// NMI_LINES lines) generators. NMI generation only exists when the
// JTLABRUN_NMI_EN macro is defined; otherwise gfx_nmin is tied high.
// The LHBL falling-edge strobe is exported so the parent can reuse it
// for the scroll double-buffer instead of keeping a second detector.
module jtlabrun_irqgen
  import jtlabrun_gfxcfg_pkg::*;
#(
  parameter int NMI_LINES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [8:0] vdump,
  input  logic       irq_en,
  input  logic       nmi_en,
  input  logic       r7_wr,
  input  logic       r7_din1,
  output logic       lhbl_fall,
  output logic       gfx_irqn,
  output logic       gfx_nmin
);

  logic lhbl_q, lhbl_d;
  logic lvbl_q, lvbl_d;
  logic armed_q, armed_d;
  logic lvbl_fall, lvbl_rise;
  logic irq_clr;
  irq_state_e state_q, state_d;

  // Edge history samples the blanking lines; armed stays low for the
  // first clock after reset so a line already low at release is not
  // mistaken for a fresh falling edge.
  always_comb begin
    lhbl_d  = LHBL;
    lvbl_d  = LVBL;
    armed_d = 1'b1;
  end

  // Edge-detector history registers, history resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhbl_q  <= 1'b1;
      lvbl_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      lhbl_q  <= lhbl_d;
      lvbl_q  <= lvbl_d;
      armed_q <= armed_d;
    end
  end

  assign lhbl_fall = armed_q & lhbl_q & ~LHBL;
  assign lvbl_fall = armed_q & lvbl_q & ~LVBL;
  assign lvbl_rise = armed_q & ~lvbl_q & LVBL;
  assign irq_clr   = r7_wr & ~r7_din1;

  // IRQ next state: a CPU write clearing irq_en overrides a
  // coincident start of vertical blank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE:   if (lvbl_fall && irq_en && !irq_clr) state_d = IRQ_ASSERT;
      IRQ_ASSERT: if (irq_clr || lvbl_rise) state_d = IRQ_IDLE;
      default:    state_d = IRQ_IDLE;
    endcase
  end

  // IRQ state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IRQ_IDLE;
    else     state_q <= state_d;
  end

  assign gfx_irqn = (state_q != IRQ_ASSERT);

`ifdef JTLABRUN_NMI_EN
  localparam int NMI_W = $clog2(NMI_LINES);

  logic nmi_q, nmi_d;
  logic line_hit;
  logic unused_vdump;

  assign unused_vdump = &{1'b0, vdump[8:NMI_W]};
  assign line_hit     = (vdump[NMI_W-1:0] == '0);

  // NMI lasts one line: latched at each line start, dropped as soon
  // as nmi_en goes away.
  always_comb begin
    nmi_d = nmi_q;
    if (!nmi_en)        nmi_d = 1'b0;
    else if (lhbl_fall) nmi_d = line_hit;
  end

  // NMI request register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nmi_q <= 1'b0;
    else     nmi_q <= nmi_d;
  end

  assign gfx_nmin = ~(nmi_q & nmi_en);
`else
  logic unused_nmi;

  assign unused_nmi = &{1'b0, nmi_en, vdump};
  assign gfx_nmin   = 1'b1;
`endif

endmodule

// File: rtl/jtlabrun_gfxcfg.sv
// CPU-facing config register bank of the Labyrinth Runner video chip.
// Decodes the config page of gfx_cs, holds scroll/control/flip
// registers, double-buffers scroll at each line start and drives the
// IRQ/NMI lines. Optional NMI generation: define JTLABRUN_NMI_EN.
module jtlabrun_gfxcfg
  import jtlabrun_gfxcfg_pkg::*;
#(
  parameter int NMI_LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        cs,
  input  logic [13:0] addr,
  input  logic        rnw,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [8:0]  vdump,
  output logic [8:0]  scrx,
  output logic [7:0]  scry,
  output logic [7:0]  ctl3,
  output logic [7:0]  ctl4,
  output logic [7:0]  ctl5,
  output logic [7:0]  ctl6,
  output logic        flip,
  output logic        gfx_irqn,
  output logic        gfx_nmin
);

  logic       cfg_hit;
  logic       cfg_wr;
  logic [2:0] reg_sel;
  logic       r7_wr;
  logic       lhbl_fall;
  logic       unused_addr;

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [8:0] scrx_q, scrx_d;
  logic [7:0] scry_q, scry_d;
  logic [7:0] dout_q, dout_d;

  // Only addr[2:0] selects a register, so the bank mirrors every 8 bytes.
  assign cfg_hit     = cs & (addr[13:12] == 2'd0) & (addr[11:8] == 4'd0);
  assign reg_sel     = addr[2:0];
  assign cfg_wr      = cfg_hit & ~rnw & cpu_cen;
  assign r7_wr       = cfg_wr & (reg_sel == REG_INT);
  assign unused_addr = &{1'b0, addr[7:3]};

  // Register bank update; R1 only implements its scroll MSB.
  always_comb begin
    regs_d = regs_q;
    if (cfg_wr) regs_d[reg_sel] = din;
    regs_d[REG_SCRXH][7:1] = 7'd0;
  end

  // Register bank storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Active scroll copies the shadows at line start; a write in that
  // same cycle is not yet in regs_q, so it shows one line later.
  always_comb begin
    scrx_d = scrx_q;
    scry_d = scry_q;
    if (lhbl_fall) begin
      scrx_d = {regs_q[REG_SCRXH][0], regs_q[REG_SCRXL]};
      scry_d = regs_q[REG_SCRY];
    end
  end

  // Registered readback, idle bus value outside the config page.
  always_comb begin
    dout_d = cfg_hit ? regs_q[reg_sel] : 8'hFF;
  end

  // Active scroll and readback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrx_q <= 9'd0;
      scry_q <= 8'd0;
      dout_q <= 8'hFF;
    end else begin
      scrx_q <= scrx_d;
      scry_q <= scry_d;
      dout_q <= dout_d;
    end
  end

  assign scrx = scrx_q;
  assign scry = scry_q;
  assign dout = dout_q;
  assign ctl3 = regs_q[REG_CTL3];
  assign ctl4 = regs_q[REG_CTL4];
  assign ctl5 = regs_q[REG_CTL5];
  assign ctl6 = regs_q[REG_CTL6];
  assign flip = regs_q[REG_INT][INT_FLIP];

  jtlabrun_irqgen #(
    .NMI_LINES (NMI_LINES)
  ) u_irqgen (
    .clk       (clk),
    .rst       (rst),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .vdump     (vdump),
    .irq_en    (regs_q[REG_INT][INT_IRQ]),
    .nmi_en    (regs_q[REG_INT][INT_NMI]),
    .r7_wr     (r7_wr),
    .r7_din1   (din[INT_IRQ]),
    .lhbl_fall (lhbl_fall),
    .gfx_irqn  (gfx_irqn),
    .gfx_nmin  (gfx_nmin)
  );

endmodule

// File: tb/tb_jtlabrun_gfxcfg.sv
// Directed bench for jtlabrun_gfxcfg: register access and mirroring,
// scroll double-buffering, IRQ handshake, NMI cadence and async reset.
module tb_jtlabrun_gfxcfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cen;
  logic        cs;
  logic [13:0] addr;
  logic        rnw;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        LHBL;
  logic        LVBL;
  logic [8:0]  vdump;
  logic [8:0]  scrx;
  logic [7:0]  scry;
  logic [7:0]  ctl3, ctl4, ctl5, ctl6;
  logic        flip;
  logic        gfx_irqn;
  logic        gfx_nmin;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] rd;

`ifdef JTLABRUN_NMI_EN
  localparam bit NMI_ON = 1'b1;
`else
  localparam bit NMI_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  jtlabrun_gfxcfg #(.NMI_LINES(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_cen  (cpu_cen),
    .cs       (cs),
    .addr     (addr),
    .rnw      (rnw),
    .din      (din),
    .dout     (dout),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .vdump    (vdump),
    .scrx     (scrx),
    .scry     (scry),
    .ctl3     (ctl3),
    .ctl4     (ctl4),
    .ctl5     (ctl5),
    .ctl6     (ctl6),
    .flip     (flip),
    .gfx_irqn (gfx_irqn),
    .gfx_nmin (gfx_nmin)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic lhbl, input logic lvbl, input logic [8:0] line);
    LHBL  = lhbl;
    LVBL  = lvbl;
    vdump = line;
    tick();
  endtask

  task automatic cpuWrite(input logic [13:0] a, input logic [7:0] d);
    cs = 1'b1; addr = a; rnw = 1'b0; din = d; cpu_cen = 1'b1;
    tick();
    cs = 1'b0; rnw = 1'b1; cpu_cen = 1'b0;
  endtask

  task automatic cpuRead(input logic [13:0] a, output logic [7:0] d);
    cs = 1'b1; addr = a; rnw = 1'b1;
    tick();
    d  = dout;
    cs = 1'b0;
  endtask

  function automatic logic expNmin(input int line);
    return (NMI_ON && (line % 32 == 0)) ? 1'b0 : 1'b1;
  endfunction

  initial begin
    rst = 1'b1; cpu_cen = 1'b0; cs = 1'b0; addr = '0; rnw = 1'b1; din = '0;
    LHBL = 1'b1; LVBL = 1'b1; vdump = 9'd5;
    tick();
    tick();
    checkOutput("rst irqn", {15'd0, gfx_irqn}, 16'd1);
    checkOutput("rst nmin", {15'd0, gfx_nmin}, 16'd1);
    checkOutput("rst dout", {8'd0, dout}, 16'h00FF);
    checkOutput("rst scrx", {7'd0, scrx}, 16'd0);
    checkOutput("rst scry", {8'd0, scry}, 16'd0);
    checkOutput("rst flip", {15'd0, flip}, 16'd0);
    rst = 1'b0;
    tick();

    $display("[TB] register readback after reset");
    for (int r = 0; r < 8; r++) begin
      cpuRead(14'(r), rd);
      checkOutput($sformatf("read R%0d", r), {8'd0, rd}, 16'h0000);
    end
    cpuRead(14'h0100, rd);
    checkOutput("read 0x0100", {8'd0, rd}, 16'h00FF);

    $display("[TB] scroll double-buffer");
    cpuWrite(14'h0000, 8'h34);
    cpuWrite(14'h0001, 8'hFF);
    cpuWrite(14'h0002, 8'h56);
    tick();
    checkOutput("scrx before line", {7'd0, scrx}, 16'd0);
    checkOutput("scry before line", {8'd0, scry}, 16'd0);
    cpuRead(14'h0001, rd);
    checkOutput("R1 masked", {8'd0, rd}, 16'h0001);
    applyStimulus(1'b0, 1'b1, 9'd5);
    checkOutput("scrx after line", {7'd0, scrx}, 16'h0134);
    checkOutput("scry after line", {8'd0, scry}, 16'h0056);
    applyStimulus(1'b1, 1'b1, 9'd6);
    LHBL = 1'b0;
    cpuWrite(14'h0002, 8'h78);
    checkOutput("scry edge write", {8'd0, scry}, 16'h0056);
    cpuRead(14'h0002, rd);
    checkOutput("R2 shadow", {8'd0, rd}, 16'h0078);
    applyStimulus(1'b1, 1'b1, 9'd7);
    applyStimulus(1'b0, 1'b1, 9'd7);
    checkOutput("scry next line", {8'd0, scry}, 16'h0078);
    checkOutput("scrx next line", {7'd0, scrx}, 16'h0134);
    applyStimulus(1'b1, 1'b1, 9'd8);

    $display("[TB] control registers");
    cpuWrite(14'h0003, 8'h11);
    cpuWrite(14'h0004, 8'hA5);
    cpuWrite(14'h0005, 8'h5A);
    cpuWrite(14'h0006, 8'hC3);
    checkOutput("ctl3", {8'd0, ctl3}, 16'h0011);
    checkOutput("ctl4", {8'd0, ctl4}, 16'h00A5);
    checkOutput("ctl5", {8'd0, ctl5}, 16'h005A);
    checkOutput("ctl6", {8'd0, ctl6}, 16'h00C3);
    cpuRead(14'h0005, rd);
    checkOutput("read R5", {8'd0, rd}, 16'h005A);

    $display("[TB] IRQ");
    cpuWrite(14'h0007, 8'h02);
    checkOutput("irqn armed", {15'd0, gfx_irqn}, 16'd1);
    applyStimulus(1'b1, 1'b0, 9'd8);
    checkOutput("irqn on vblank", {15'd0, gfx_irqn}, 16'd0);
    cpuWrite(14'h0007, 8'h00);
    checkOutput("irqn ack", {15'd0, gfx_irqn}, 16'd1);
    applyStimulus(1'b1, 1'b1, 9'd9);
    cpuWrite(14'h0007, 8'h02);
    LVBL = 1'b0;
    cpuWrite(14'h0007, 8'h00);
    checkOutput("irqn same-cycle clr", {15'd0, gfx_irqn}, 16'd1);
    tick();
    checkOutput("irqn stays high", {15'd0, gfx_irqn}, 16'd1);
    applyStimulus(1'b1, 1'b1, 9'd9);
    cpuWrite(14'h0007, 8'h02);
    applyStimulus(1'b1, 1'b0, 9'd9);
    checkOutput("irqn second vblank", {15'd0, gfx_irqn}, 16'd0);
    applyStimulus(1'b1, 1'b1, 9'd9);
    checkOutput("irqn vblank end", {15'd0, gfx_irqn}, 16'd1);

    $display("[TB] NMI cadence");
    cpuWrite(14'h0007, 8'h01);
    for (int line = 0; line < 96; line++) begin
      applyStimulus(1'b1, 1'b1, 9'(line));
      applyStimulus(1'b0, 1'b1, 9'(line));
      checkOutput($sformatf("nmin line %0d", line), {15'd0, gfx_nmin}, {15'd0, expNmin(line)});
    end
    applyStimulus(1'b1, 1'b1, 9'h100);
    applyStimulus(1'b0, 1'b1, 9'h100);
    checkOutput("nmin line 0x100", {15'd0, gfx_nmin}, {15'd0, expNmin(32'h100)});
    cpuWrite(14'h0007, 8'h00);
    checkOutput("nmin released", {15'd0, gfx_nmin}, 16'd1);
    applyStimulus(1'b1, 1'b1, 9'h101);

    $display("[TB] mirrors");
    cpuWrite(14'h00FF, 8'h08);
    checkOutput("mirror ctl3 kept", {8'd0, ctl3}, 16'h0011);
    checkOutput("mirror flip", {15'd0, flip}, 16'd1);
    cpuRead(14'h0007, rd);
    checkOutput("mirror R7", {8'd0, rd}, 16'h0008);
    cpuWrite(14'h00FB, 8'h22);
    checkOutput("mirror ctl3", {8'd0, ctl3}, 16'h0022);
    cpuWrite(14'h0107, 8'h00);
    checkOutput("off-page write", {15'd0, flip}, 16'd1);
    cpuWrite(14'h0007, 8'hF8);
    cpuRead(14'h0037, rd);
    checkOutput("R7 spare bits", {8'd0, rd}, 16'h00F8);

    $display("[TB] async reset during IRQ");
    cpuWrite(14'h0007, 8'h02);
    applyStimulus(1'b1, 1'b0, 9'h0F0);
    checkOutput("irqn before rst", {15'd0, gfx_irqn}, 16'd0);
    rst = 1'b1;
    #1;
    checkOutput("irqn async rst", {15'd0, gfx_irqn}, 16'd1);
    tick();
    checkOutput("flip in rst", {15'd0, flip}, 16'd0);
    rst = 1'b0;
    cpuWrite(14'h0007, 8'h02);
    tick();
    tick();
    checkOutput("no irq after rst", {15'd0, gfx_irqn}, 16'd1);
    applyStimulus(1'b1, 1'b1, 9'h0F0);
    checkOutput("no irq on rise", {15'd0, gfx_irqn}, 16'd1);
    applyStimulus(1'b1, 1'b0, 9'h0F0);
    checkOutput("irq real vblank", {15'd0, gfx_irqn}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
